// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard: per-register write countdowns gate issue of an
// even/odd instruction pair, with in-order and intra-pair hazard rules.
module issue_scoreboard #(
    parameter int unsigned NREG = 128,
    parameter int unsigned LATW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            even_valid,
    input  logic            odd_valid,
    input  logic [6:0]      even_ra,
    input  logic [6:0]      even_rb,
    input  logic [6:0]      even_rc,
    input  logic            even_ra_use,
    input  logic            even_rb_use,
    input  logic            even_rc_use,
    input  logic [6:0]      odd_ra,
    input  logic [6:0]      odd_rb,
    input  logic [6:0]      odd_rs,
    input  logic            odd_ra_use,
    input  logic            odd_rb_use,
    input  logic            odd_rs_use,
    input  logic [6:0]      even_rt,
    input  logic [6:0]      odd_rt,
    input  logic            even_wr,
    input  logic            odd_wr,
    input  logic [LATW-1:0] even_lat,
    input  logic [LATW-1:0] odd_lat,
    output logic            even_issue,
    output logic            odd_issue,
    output logic [15:0]     stall_cycles
);

    localparam int unsigned AW = 7;

    logic [LATW-1:0] cnt [NREG];
    logic [NREG-1:0] busy;

    logic even_src_busy;
    logic odd_src_busy;
    logic even_ok;
    logic odd_ok;
    logic pair_raw;
    logic pair_waw;
    logic even_load;
    logic odd_load;
    logic stall_now;
    logic [15:0] stall_q;

    // Busy is taken from the registered countdown only: no bypass of a write
    // landing in the current cycle.
    always_comb begin
        even_src_busy = (even_ra_use && busy[even_ra])
                      || (even_rb_use && busy[even_rb])
                      || (even_rc_use && busy[even_rc]);
        odd_src_busy  = (odd_ra_use && busy[odd_ra])
                      || (odd_rb_use && busy[odd_rb])
                      || (odd_rs_use && busy[odd_rs]);

        even_ok  = even_valid && !even_src_busy && !(even_wr && busy[even_rt]);

        pair_raw = even_wr && ((odd_ra_use && (odd_ra == even_rt))
                            || (odd_rb_use && (odd_rb == even_rt))
                            || (odd_rs_use && (odd_rs == even_rt)));
        pair_waw = even_wr && odd_wr && (even_rt == odd_rt);

        odd_ok   = odd_valid && !odd_src_busy && !(odd_wr && busy[odd_rt])
                && !(even_valid && !even_ok)
                && !(even_ok && (pair_raw || pair_waw));
    end

    // Outputs forced low combinationally while reset is held.
    assign even_issue = reset && even_ok;
    assign odd_issue  = reset && odd_ok;

    assign even_load = even_issue && even_wr && (even_lat != '0);
    assign odd_load  = odd_issue && odd_wr && (odd_lat != '0);

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        assign busy[g] = |cnt[g];

        // Even and odd never load the same rt in one cycle (pair WAW rule).
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt[g] <= '0;
            end else if (even_load && (even_rt == AW'(g))) begin
                cnt[g] <= even_lat;
            end else if (odd_load && (odd_rt == AW'(g))) begin
                cnt[g] <= odd_lat;
            end else if (cnt[g] != '0) begin
                cnt[g] <= cnt[g] - 1'b1;
            end
        end
    end

    assign stall_now = (even_valid && !even_issue) || (odd_valid && !odd_issue);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 128, number of tracked registers (7-bit addresses).
REQ-002 SHALL have parameter LATW, default 3, width of latency and per-register countdown.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports even_valid, odd_valid  input  1 each  instruction presented in that pipe slot.
REQ-006 SHALL have ports even_ra, even_rb, even_rc  input  7 each  even-pipe source addresses, with even_ra_use, even_rb_use, even_rc_use  input  1 each.
REQ-007 SHALL have ports odd_ra, odd_rb, odd_rs  input  7 each  odd-pipe sources (odd_rs = store data), with odd_ra_use, odd_rb_use, odd_rs_use  input  1 each.
REQ-008 SHALL have ports even_rt, odd_rt  input  7 each  destination addresses; even_wr, odd_wr  input  1 each  instruction writes rt.
REQ-009 SHALL have ports even_lat, odd_lat  input  LATW each  cycles from issue to register-file write.
REQ-010 SHALL have ports even_issue, odd_issue  output  1 each  slot issues this cycle.
REQ-011 SHALL have port stall_cycles  output  16  count of cycles where a valid slot did not issue.

Function
REQ-012 SHALL hold one LATW-bit countdown per register; register busy iff countdown != 0.
REQ-013 Each cycle every nonzero countdown SHALL decrement by 1, except where overwritten per REQ-014.
REQ-014 On issue with wr=1 and lat != 0, countdown[rt] SHALL load lat (load wins over decrement); lat = 0 SHALL load nothing.
REQ-015 even_issue SHALL be combinational: even_valid AND no used even source busy AND NOT (even_wr AND even_rt busy).
REQ-016 odd_issue SHALL be combinational: odd_valid AND no used odd source busy AND NOT (odd_wr AND odd_rt busy) AND in-order/pair rules of REQ-017..019.
REQ-017 In-order: if even_valid=1 and even_issue=0, odd_issue SHALL be 0.
REQ-018 Intra-pair RAW: if even_issue=1, even_wr=1 and any used odd source equals even_rt, odd_issue SHALL be 0.
REQ-019 Intra-pair WAW: if even_issue=1 and both wr=1 with even_rt == odd_rt, odd_issue SHALL be 0.
REQ-020 No bypass: register file reads see pre-write values, so a source is blocked until its countdown reads 0 (reads in the cycle countdown=1 still stall).
REQ-021 Busy checks SHALL use the registered countdown of the current cycle, not the next-cycle value.
REQ-022 Issue uses no ready/ack; a non-issued slot SHALL be re-presented by upstream unchanged; block holds no instruction state.
REQ-023 stall_cycles SHALL increment by 1 in any cycle where (even_valid AND NOT even_issue) OR (odd_valid AND NOT odd_issue); saturates at 16'hFFFF.
REQ-024 Simultaneous even and odd loads to different rt SHALL both take effect in the same edge.

Reset
REQ-025 reset=0 SHALL asynchronously clear all countdowns to 0 and stall_cycles to 0.
REQ-026 During reset, even_issue and odd_issue SHALL be 0 regardless of inputs.
REQ-027 Reset asserted mid-operation SHALL discard all pending busy state; first cycle after release all registers free.
REQ-028 Reset deassertion SHALL take effect at the next rising edge without glitching outputs.

Verification
REQ-029 Reset, then even_valid=1, even_rt=5, even_wr=1, even_lat=3 -> even_issue=1; next cycle even source ra=5 used -> even_issue=0 for 3 cycles, 1 on the 4th; stall_cycles=3.
REQ-030 Same cycle even_rt=5 wr, odd_ra=5 used -> even_issue=1, odd_issue=0; next cycle odd stalls until countdown[5]=0.
REQ-031 Even source busy (reg 3, countdown 2), odd independent -> even_issue=0, odd_issue=0 (in-order), stall_cycles +1 per cycle.
REQ-032 even_rt=odd_rt=7 both wr, no other hazards -> even_issue=1, odd_issue=0; next cycle odd_issue=0 (reg 7 busy).
REQ-033 Load reg 9 lat=7, assert reset after 2 cycles, release -> source reg 9 issues immediately; stall_cycles=0.
REQ-034 Force 65540 stall cycles -> stall_cycles holds 16'hFFFF.
